// File: rtl/trdb_stream_word_buffer.sv
// Word FIFO behind the 8-bit stream aligner: valid-only capture, valid/ready readout,
// drop accounting when full. Optional gap marker insertion under TRDB_DROP_MARKER_EN.
module trdb_stream_word_buffer #(
  parameter int DEPTH      = 16,
  parameter int DROP_CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [31:0]                data_i,
  input  logic                       valid_i,
  input  logic                       clear_i,
  output logic [31:0]                data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     fill_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overflow_o,
  output logic [DROP_CNT_W-1:0]      drop_cnt_o,
  output logic [1:0]                 state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] ST_NORMAL   = 2'd0;
  localparam logic [1:0] ST_DROPPING = 2'd1;
  localparam logic [1:0] ST_MARKER   = 2'd2;

  // Handshake: the consumer takes the head word in any cycle where valid_o && ready_i;
  // the producer side has no ready, so every valid_i word is stored or dropped that cycle.

  logic [31:0]           mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]         fill;
  logic                  full, empty, pop;
  logic                  wr_en, drop;
  logic [31:0]           wr_data;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  overflow_q;

  assign fill  = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop   = !empty && ready_i;

  assign drop_cnt_d = (drop && !(&drop_cnt_q)) ? drop_cnt_q + DROP_CNT_W'(1) : drop_cnt_q;

`ifdef TRDB_DROP_MARKER_EN
  logic [1:0]            state_q, state_d;
  logic [DROP_CNT_W-1:0] ep_cnt_q, ep_cnt_d, ep_inc, ep_next;
  logic [PW-1:0]         fill_after_pop;
  logic [15:0]           ep_tag;

  assign ep_inc         = (&ep_cnt_q) ? ep_cnt_q : ep_cnt_q + DROP_CNT_W'(1);
  assign ep_next        = valid_i ? ep_inc : ep_cnt_q;
  assign fill_after_pop = fill - PW'(pop);
  assign ep_tag         = 16'(ep_next);

  // Once a word is lost, everything is dropped until the marker can be placed,
  // so the consumer sees stored words, then the marker, then post-gap words.
  always_comb begin
    wr_en    = 1'b0;
    wr_data  = data_i;
    drop     = 1'b0;
    state_d  = state_q;
    ep_cnt_d = ep_cnt_q;
    case (state_q)
      ST_NORMAL: begin
        if (valid_i) begin
          if (!full || pop) begin
            wr_en = 1'b1;
          end else begin
            drop     = 1'b1;
            ep_cnt_d = ep_inc;
            state_d  = ST_DROPPING;
          end
        end
      end
      ST_DROPPING: begin
        drop     = valid_i;
        ep_cnt_d = ep_next;
        if (fill_after_pop <= PW'(DEPTH - 2)) state_d = ST_MARKER;
      end
      ST_MARKER: begin
        drop     = valid_i;
        wr_en    = 1'b1;
        wr_data  = {16'hFADE, ep_tag};
        ep_cnt_d = '0;
        state_d  = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_NORMAL;
      ep_cnt_q <= '0;
    end else if (clear_i) begin
      state_q  <= ST_NORMAL;
      ep_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ep_cnt_q <= ep_cnt_d;
    end
  end

  assign state_o = state_q;
`else
  always_comb begin
    wr_data = data_i;
    wr_en   = valid_i && (!full || pop);
    drop    = valid_i && full && !pop;
  end

  assign state_o = ST_NORMAL;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_q | drop;
    end
  end

  // Storage carries no reset; contents are only visible through valid pointers.
  always_ff @(posedge clk_i) begin
    if (!clear_i && wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign valid_o    = !empty;
  assign data_o     = empty ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]];
  assign fill_o     = fill;
  assign full_o     = full;
  assign empty_o    = empty;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_trdb_stream_word_buffer.sv
// Bench for trdb_stream_word_buffer: directed scenarios plus random traffic against a
// queue-based reference of the buffer contents and drop accounting.
module tb_trdb_stream_word_buffer;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   data_i;
  logic          valid_i, clear_i, ready_i;
  logic [31:0]   data_o;
  logic          valid_o, full_o, empty_o, overflow_o;
  logic [PW-1:0] fill_o;
  logic [DW-1:0] drop_cnt_o;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  trdb_stream_word_buffer #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .clear_i    (clear_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .fill_o     (fill_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o),
    .state_o    (state_o)
  );

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;

  // reference state
  logic [31:0]   exp_q[$];
  logic [DW-1:0] m_drop;
  logic          m_ovf;
  logic [1:0]    m_state;
  logic [DW-1:0] m_ep;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] x);
    return (&x) ? x : x + DW'(1);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_drop  = '0;
    m_ovf   = 1'b0;
    m_state = 2'd0;
    m_ep    = '0;
  endtask

  task automatic model_drop();
    m_drop = sat_inc(m_drop);
    m_ovf  = 1'b1;
  endtask

  task automatic check_status();
    int sz;
    sz = exp_q.size();
    check_eq("fill",     32'(fill_o),  32'(sz));
    check_eq("valid",    32'(valid_o), 32'(sz != 0));
    check_eq("empty",    32'(empty_o), 32'(sz == 0));
    check_eq("full",     32'(full_o),  32'(sz == DEPTH));
    check_eq("head",     data_o,       (sz != 0) ? exp_q[0] : 32'h0);
    check_eq("overflow", 32'(overflow_o), 32'(m_ovf));
    check_eq("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
`ifdef TRDB_DROP_MARKER_EN
    check_eq("state",    32'(state_o), 32'(m_state));
`endif
  endtask

  // One clock cycle: starts and ends on a falling edge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic c);
    int sz;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    clear_i = c;
    check_status();
    if (c) begin
      model_reset();
    end else begin
      if (r && exp_q.size() != 0) check_eq("pop_data", data_o, exp_q.pop_front());
      sz = exp_q.size();
`ifdef TRDB_DROP_MARKER_EN
      case (m_state)
        2'd0: if (v) begin
          if (sz < DEPTH) exp_q.push_back(d);
          else begin model_drop(); m_ep = sat_inc(m_ep); m_state = 2'd1; end
        end
        2'd1: begin
          if (v) begin model_drop(); m_ep = sat_inc(m_ep); end
          if (sz <= DEPTH - 2) m_state = 2'd2;
        end
        default: begin
          if (v) begin model_drop(); m_ep = sat_inc(m_ep); end
          exp_q.push_back({16'hFADE, 16'(m_ep)});
          m_ep    = '0;
          m_state = 2'd0;
        end
      endcase
`else
      if (v) begin
        if (sz < DEPTH) exp_q.push_back(d);
        else model_drop();
      end
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    valid_i = 1'b0; data_i = '0; ready_i = 1'b0; clear_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_status();
    rst_n = 1'b1;
  endtask

  initial begin
    apply_reset();

    // back-to-back pushes drain in order, then buffer goes empty
    cycle(1'b1, 32'h11111111, 1'b1, 1'b0);
    cycle(1'b1, 32'h22222222, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("t1_valid_after", 32'(valid_o), 32'h0);

    // overfill by three with no consumer
    for (int i = 0; i < DEPTH + 3; i++) cycle(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    check_eq("t2_full", 32'(full_o), 32'h1);
    check_eq("t2_fill", 32'(fill_o), DEPTH);
    check_eq("t2_drop", 32'(drop_cnt_o), 32'h3);
    check_eq("t2_ovf",  32'(overflow_o), 32'h1);
    for (int i = 0; i < DEPTH + 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("t2_drained", 32'(empty_o), 32'h1);

    // full with simultaneous push and pop: no drop
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'hB0B0_0003, 1'b1, 1'b0);
    check_eq("t3_fill", 32'(fill_o), DEPTH);
    check_eq("t3_drop", 32'(drop_cnt_o), 32'h0);

    // one drop, then clear while full with valid_i high
    cycle(1'b1, 32'hC0C0_0001, 1'b0, 1'b0);
    cycle(1'b1, 32'hC0C0_0002, 1'b0, 1'b1);
    check_eq("t4_fill",  32'(fill_o), 32'h0);
    check_eq("t4_empty", 32'(empty_o), 32'h1);
    check_eq("t4_drop",  32'(drop_cnt_o), 32'h0);
    check_eq("t4_ovf",   32'(overflow_o), 32'h0);

    // fill, drop five, pop two, idle, then drain
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'hDDDD_0000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("t5_drop", 32'(drop_cnt_o), 32'h5);
`ifdef TRDB_DROP_MARKER_EN
    check_eq("t5_fill",  32'(fill_o), DEPTH - 1);
    check_eq("t5_state", 32'(state_o), 32'h0);
`else
    check_eq("t5_fill",  32'(fill_o), DEPTH - 2);
`endif
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // drop counter saturation
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + (1 << DW) + 2; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    check_eq("t6_drop_sat", 32'(drop_cnt_o), 32'((1 << DW) - 1));
    check_eq("t6_ovf", 32'(overflow_o), 32'h1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 80) == 0));
    end

    // asynchronous reset in the middle of traffic
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check_eq("arst_valid", 32'(valid_o), 32'h0);
    check_eq("arst_fill",  32'(fill_o), 32'h0);
    check_eq("arst_data",  data_o, 32'h0);
    model_reset();
    valid_i = 1'b0; clear_i = 1'b0; ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'hF00D_0001, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
